// File: rtl/pipe_accmul_unit.sv
// pipe_accmul_unit: 3-stage valid/ready pipeline (tag add, accumulate, multiply).
// Define PIPE_ACC_SAT_EN for a saturating accumulator with a sticky ovf flag.
module pipe_accmul_unit #(
    parameter int W    = 8,
    parameter int CW   = 6,
    parameter bit DOWN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     s1,
    output logic [2*W-1:0]   s2,
    output logic             ovf
);

    logic          v1, v2, v3;
    logic          adv1, adv2, adv3, accept;
    logic [CW-1:0] c, c_base, c_next;
    logic [W-1:0]  r1, r2, k1, d, b2, acc, acc_base, acc_new;

    assign adv3      = !v3 || out_ready;
    assign adv2      = !v2 || adv3;
    assign adv1      = !v1 || adv2;
    assign in_ready  = reset && adv1;
    assign accept    = in_valid && in_ready;
    assign out_valid = v3;

    // A clear in the same cycle as an accept tags that sample 0 and steps from 0
    assign c_base   = clr ? '0 : c;
    assign c_next   = DOWN ? c_base - CW'(1) : c_base + CW'(1);
    assign acc_base = clr ? '0 : acc;

`ifdef PIPE_ACC_SAT_EN
    logic [W:0] sum;
    assign sum     = {1'b0, acc_base} + {1'b0, d};
    assign acc_new = sum[W] ? '1 : sum[W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
        end else if (adv3 && v2 && sum[W]) begin
            ovf <= 1'b1;
        end
    end
`else
    assign acc_new = acc_base + d;
    assign ovf     = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c   <= '0;
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            r1  <= '0;
            r2  <= '0;
            k1  <= '0;
            d   <= '0;
            b2  <= '0;
            acc <= '0;
            s1  <= '0;
            s2  <= '0;
        end else begin
            if (accept) begin
                c <= c_next;
            end else if (clr) begin
                c <= '0;
            end

            if (adv1) begin
                v1 <= accept;
                if (accept) begin
                    r1 <= a;
                    r2 <= b;
                    k1 <= W'(c_base);
                end
            end

            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    d  <= r1 + k1;
                    b2 <= r2;
                end
            end

            if (adv3) begin
                v3 <= v2;
            end

            // s1/s2 only change on a stage-3 fire, so they hold under a stall
            if (adv3 && v2) begin
                acc <= acc_new;
                s1  <= acc_new;
                s2  <= (2*W)'(b2) * (2*W)'(d);
            end else if (clr) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_accmul_unit.sv
// Self-checking bench for pipe_accmul_unit (W=8, CW=6, DOWN=1), directed plus random traffic.
module tb_pipe_accmul_unit;

    logic        clk;
    logic        reset;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  s1;
    logic [15:0] s2;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [7:0]  s1;
        logic [15:0] s2;
    } exp_t;

    exp_t q[$];
    int   m_c;
    int   m_acc;

    pipe_accmul_unit #(.W(8), .CW(6), .DOWN(1'b1)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .s1(s1), .s2(s2), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference: tag counts down mod 64, d = a + tag, acc wraps or saturates at 255
    task automatic model_push(input int av, input int bv);
        int   tag;
        int   dd;
        int   sum;
        exp_t e;
        tag = m_c;
        m_c = (m_c + 63) % 64;
        dd  = (av + tag) % 256;
        sum = m_acc + dd;
`ifdef PIPE_ACC_SAT_EN
        if (sum > 255) sum = 255;
`else
        sum = sum % 256;
`endif
        m_acc = sum;
        e.s1  = 8'(sum);
        e.s2  = 16'(dd * bv);
        q.push_back(e);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cyc();
        cyc();
        reset = 1'b1;
        q.delete();
        m_c   = 0;
        m_acc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; clr = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = 8'd3; b = 8'd4;
        #2;
        reset = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        cyc();
        cyc();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (s1 !== 8'd0) begin fails++; $display("FAIL reset_s1 got=%0d exp=0", s1); end
        tests++; if (s2 !== 16'd0) begin fails++; $display("FAIL reset_s2 got=%0d exp=0", s2); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_held got=%b exp=0", in_ready); end
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        logic [7:0]  e1 [3];
        logic [15:0] e2 [3];
        e1 = '{8'd5, 8'd73, 8'd140};
        e2 = '{16'd35, 16'd476, 16'd469};
        do_reset();
        in_valid = 1'b1; a = 8'd5; b = 8'd7;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            tests++;
            if (out_valid !== (k >= 3)) begin fails++; $display("FAIL basic_latency k=%0d got=%b exp=%b", k, out_valid, (k >= 3)); end
            if (k >= 3) begin
                tests++; if (s1 !== e1[k-3]) begin fails++; $display("FAIL basic_s1 k=%0d got=%0d exp=%0d", k, s1, e1[k-3]); end
                tests++; if (s2 !== e2[k-3]) begin fails++; $display("FAIL basic_s2 k=%0d got=%0d exp=%0d", k, s2, e2[k-3]); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall();
        int   n_acc;
        int   n_out;
        logic have;
        exp_t held;
        exp_t e;
        do_reset();
        n_acc = 0; n_out = 0; have = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            #1;
            if (in_valid && in_ready) begin model_push(int'(a), int'(b)); n_acc++; end
            if (out_valid) begin
                if (!have) begin
                    held.s1 = s1; held.s2 = s2; have = 1'b1;
                end else begin
                    tests++;
                    if (s1 !== held.s1 || s2 !== held.s2) begin
                        fails++; $display("FAIL stall_hold got=%0d/%0d exp=%0d/%0d", s1, s2, held.s1, held.s2);
                    end
                end
            end
            cyc();
        end
        tests++; if (n_acc != 3) begin fails++; $display("FAIL stall_accepts got=%0d exp=3", n_acc); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        tests++;
        if (!have || s1 !== held.s1 || s2 !== held.s2) begin
            fails++; $display("FAIL stall_hold_end got=%0d/%0d exp=%0d/%0d", s1, s2, held.s1, held.s2);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = (i < 4);
            a = 8'($urandom); b = 8'($urandom);
            #1;
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL stall_extra_output got=%0d/%0d exp=none", s1, s2);
                end else begin
                    e = q.pop_front();
                    n_out++;
                    if (s1 !== e.s1 || s2 !== e.s2) begin
                        fails++; $display("FAIL stall_order got=%0d/%0d exp=%0d/%0d", s1, s2, e.s1, e.s2);
                    end
                end
            end
            if (in_valid && in_ready) begin model_push(int'(a), int'(b)); n_acc++; end
            cyc();
        end
        tests++; if (n_out != n_acc) begin fails++; $display("FAIL stall_count got=%0d exp=%0d", n_out, n_acc); end
    endtask

    task automatic test_wrap();
        int n_in;
        int n_out;
        int ex;
        do_reset();
        n_in = 0; n_out = 0;
        in_valid = 1'b1; a = 8'd0; b = 8'd1;
        for (int i = 0; i < 90 && n_out < 65; i++) begin
            #1;
            if (out_valid && out_ready) begin
                ex = (64 - n_out) % 64;
                tests++;
                if (s2 !== 16'(ex)) begin fails++; $display("FAIL wrap_tag n=%0d got=%0d exp=%0d", n_out, s2, ex); end
                n_out++;
            end
            if (in_valid && in_ready) n_in++;
            cyc();
            if (n_in == 65) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        tests++; if (n_out != 65) begin fails++; $display("FAIL wrap_count got=%0d exp=65", n_out); end
    endtask

    task automatic test_clr();
        logic [7:0]  g1 [4];
        logic [15:0] g2 [4];
        logic [7:0]  e1 [3];
        logic [15:0] e2 [3];
        int          n;
        e1 = '{8'd3, 8'd7, 8'd70};
        e2 = '{16'd6, 16'd4, 16'd63};
        do_reset();
        n = 0;
        in_valid = 1'b1; a = 8'd10; b = 8'd3;
        cyc();
        a = 8'd198; b = 8'd2;
        cyc();
        in_valid = 1'b0;
        cyc();
        tests++; if (s1 !== 8'd10) begin fails++; $display("FAIL clr_pre_s1 got=%0d exp=10", s1); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        tests++; if (s1 !== 8'd5) begin fails++; $display("FAIL clr_fire_s1 got=%0d exp=5", s1); end
        tests++; if (s2 !== 16'd10) begin fails++; $display("FAIL clr_fire_s2 got=%0d exp=10", s2); end
        in_valid = 1'b1; a = 8'd3; b = 8'd2;
        cyc();
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin a = 8'd4; b = 8'd1; clr = 1'b1; end
            else if (i == 1) begin a = 8'd0; b = 8'd1; clr = 1'b0; end
            else in_valid = 1'b0;
            #1;
            if (out_valid && out_ready && n < 4) begin g1[n] = s1; g2[n] = s2; n++; end
            cyc();
        end
        tests++; if (n != 3) begin fails++; $display("FAIL clr_count got=%0d exp=3", n); end
        for (int i = 0; i < 3 && i < n; i++) begin
            tests++;
            if (g1[i] !== e1[i] || g2[i] !== e2[i]) begin
                fails++; $display("FAIL clr_seq i=%0d got=%0d/%0d exp=%0d/%0d", i, g1[i], g2[i], e1[i], e2[i]);
            end
        end
    endtask

    task automatic test_sat();
        logic [7:0] e_s1;
        logic       e_ovf;
`ifdef PIPE_ACC_SAT_EN
        e_s1 = 8'd255; e_ovf = 1'b1;
`else
        e_s1 = 8'd167; e_ovf = 1'b0;
`endif
        do_reset();
        in_valid = 1'b1; a = 8'd180; b = 8'd1;
        cyc();
        cyc();
        in_valid = 1'b0;
        cyc();
        tests++; if (s1 !== 8'd180) begin fails++; $display("FAIL sat_first got=%0d exp=180", s1); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL sat_ovf_first got=%b exp=0", ovf); end
        cyc();
        tests++; if (s1 !== e_s1) begin fails++; $display("FAIL sat_second got=%0d exp=%0d", s1, e_s1); end
        tests++; if (s2 !== 16'd243) begin fails++; $display("FAIL sat_s2 got=%0d exp=243", s2); end
        tests++; if (ovf !== e_ovf) begin fails++; $display("FAIL sat_ovf got=%b exp=%b", ovf, e_ovf); end
        cyc();
        cyc();
        tests++; if (ovf !== e_ovf) begin fails++; $display("FAIL sat_ovf_sticky got=%b exp=%b", ovf, e_ovf); end
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL sat_ovf_clr got=%b exp=0", ovf); end
    endtask

    task automatic test_midreset();
        logic got;
        do_reset();
        in_valid = 1'b1; a = 8'd9; b = 8'd2;
        cyc();
        cyc();
        cyc();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_full got=%b exp=1", out_valid); end
        reset = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        tests++; if (s1 !== 8'd0) begin fails++; $display("FAIL midrst_s1 got=%0d exp=0", s1); end
        tests++; if (s2 !== 16'd0) begin fails++; $display("FAIL midrst_s2 got=%0d exp=0", s2); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
        a = 8'd5; b = 8'd7;
        cyc();
        reset = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (out_valid) begin
                got = 1'b1;
                tests++;
                if (s1 !== 8'd5 || s2 !== 16'd35) begin
                    fails++; $display("FAIL midrst_first got=%0d/%0d exp=5/35", s1, s2);
                end
            end
            cyc();
        end
        in_valid = 1'b0;
        if (!got) begin tests++; fails++; $display("FAIL midrst_timeout got=no_output exp=output"); end
    endtask

    task automatic test_random();
        logic hold_pend;
        exp_t held;
        exp_t e;
        logic exp_rdy;
        do_reset();
        hold_pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            a = 8'($urandom); b = 8'($urandom);
            #1;
            exp_rdy = (q.size() < 3) || out_ready;
            tests++;
            if (in_ready !== exp_rdy) begin
                fails++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, in_ready, exp_rdy);
            end
            if (hold_pend) begin
                tests++;
                if (out_valid !== 1'b1 || s1 !== held.s1 || s2 !== held.s2) begin
                    fails++; $display("FAIL rand_hold cyc=%0d got=%0d/%0d exp=%0d/%0d", i, s1, s2, held.s1, held.s2);
                end
            end
            hold_pend = out_valid && !out_ready;
            held.s1 = s1; held.s2 = s2;
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_extra cyc=%0d got=%0d/%0d exp=none", i, s1, s2);
                end else begin
                    e = q.pop_front();
                    if (s1 !== e.s1 || s2 !== e.s2) begin
                        fails++; $display("FAIL rand_data cyc=%0d got=%0d/%0d exp=%0d/%0d", i, s1, s2, e.s1, e.s2);
                    end
                end
            end
            if (in_valid && in_ready) model_push(int'(a), int'(b));
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++; $display("FAIL rand_drain_extra got=%0d/%0d exp=none", s1, s2);
                end else begin
                    e = q.pop_front();
                    if (s1 !== e.s1 || s2 !== e.s2) begin
                        fails++; $display("FAIL rand_drain got=%0d/%0d exp=%0d/%0d", s1, s2, e.s1, e.s2);
                    end
                end
            end
            cyc();
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL rand_lost got=%0d exp=0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_clr();
        test_sat();
        test_midreset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
